// File: rtl/trigger_scaler_pkg.sv
// Shared constants for the trigger scaler bank: channel map and default sizing.
// Bits 5:0 carry the L1 top/mid/bot pulses for phi 0 then phi 1; bits 7:6 carry L2 phi 0/1.
package trigger_scaler_pkg;

  localparam int SC_TOP0 = 0;
  localparam int SC_MID0 = 1;
  localparam int SC_BOT0 = 2;
  localparam int SC_TOP1 = 3;
  localparam int SC_MID1 = 4;
  localparam int SC_BOT1 = 5;
  localparam int SC_L2_0 = 6;
  localparam int SC_L2_1 = 7;

  localparam int SC_DEF_NCHAN  = 8;
  localparam int SC_DEF_WIDTH  = 16;
  localparam int SC_DEF_PERIOD = 100000;

endpackage

// File: rtl/trigger_scaler_counter.sv
// One scaler channel: saturating gate counter with sticky saturation flag,
// plus the holding and overflow registers loaded at the end of each gate.
module trigger_scaler_counter #(
  parameter int WIDTH = 16
) (
  input  logic             mclk_i,
  input  logic             rst_n_i,
  input  logic             inc_i,
  input  logic             gate_end_i,
  output logic [WIDTH-1:0] hold_o,
  output logic             ovf_o
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             sat_q, sat_d, sat_inc;
  logic             ovf_q, ovf_d;

  // cnt_inc/sat_inc already include this cycle's pulse, so the closing
  // snapshot takes it and the fresh gate starts clean at zero.
  always_comb begin
    cnt_inc = cnt_q;
    if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_inc = cnt_q + WIDTH'(1);
    end
    sat_inc = sat_q | (cnt_inc == CNT_MAX);

    cnt_d  = cnt_inc;
    sat_d  = sat_inc;
    hold_d = hold_q;
    ovf_d  = ovf_q;
    if (gate_end_i) begin
      hold_d = cnt_inc;
      ovf_d  = sat_inc;
      cnt_d  = '0;
      sat_d  = 1'b0;
    end
  end

  always_ff @(posedge mclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      sat_q  <= 1'b0;
      hold_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
      hold_q <= hold_d;
      ovf_q  <= ovf_d;
    end
  end

  assign hold_o = hold_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/trigger_scaler_bank.sv
// Per-channel L1/L2 scaler bank: gate timer (internal period or PPS edge),
// per-channel snapshot counters, snapshot counter and registered readout mux.
module trigger_scaler_bank
  import trigger_scaler_pkg::*;
#(
  parameter int NCHAN         = SC_DEF_NCHAN,
  parameter int WIDTH         = SC_DEF_WIDTH,
  parameter int PERIOD_CYCLES = SC_DEF_PERIOD
) (
  input  logic                     mclk_i,
  input  logic                     rst_n_i,
  input  logic [NCHAN-1:0]         flag_i,
  input  logic [NCHAN-1:0]         mask_i,
  input  logic                     pps_mode_i,
  input  logic                     pps_i,
  input  logic [$clog2(NCHAN)-1:0] sel_i,
  output logic [WIDTH-1:0]         dat_o,
  output logic [NCHAN-1:0]         ovf_o,
  output logic                     update_o,
  output logic [15:0]              gate_cnt_o
);

  localparam int              PC_W    = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PERIOD_CYCLES - 1);

  logic [PC_W-1:0]  pc_q, pc_d;
  logic             pps_q;
  logic             pps_rise;
  logic             gate_end;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic             update_q;
  logic [15:0]      gate_cnt_q, gate_cnt_d;
  logic [NCHAN-1:0] inc;
  logic [WIDTH-1:0] hold [NCHAN];

  // The edge register tracks pps_i in both modes, so an edge that happened
  // while in internal mode is never replayed after switching to PPS mode.
  assign pps_rise = pps_i & ~pps_q;
  assign gate_end = pps_mode_i ? pps_rise : (pc_q == PC_LAST);

  // In PPS mode pc parks at the end of its range rather than wrapping.
  always_comb begin
    pc_d = pc_q;
    if (gate_end) begin
      pc_d = '0;
    end else if (pc_q != PC_LAST) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  assign inc        = flag_i & ~mask_i;
  assign gate_cnt_d = gate_cnt_q + 16'(gate_end);

  always_comb begin
    dat_d = '0;
    if (int'(sel_i) < NCHAN) begin
      dat_d = hold[sel_i];
    end
  end

  always_ff @(posedge mclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_q       <= '0;
      pps_q      <= 1'b0;
      dat_q      <= '0;
      update_q   <= 1'b0;
      gate_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      pps_q      <= pps_i;
      dat_q      <= dat_d;
      update_q   <= gate_end;
      gate_cnt_q <= gate_cnt_d;
    end
  end

  for (genvar k = 0; k < NCHAN; k++) begin : g_chan
    trigger_scaler_counter #(
      .WIDTH(WIDTH)
    ) u_cnt (
      .mclk_i    (mclk_i),
      .rst_n_i   (rst_n_i),
      .inc_i     (inc[k]),
      .gate_end_i(gate_end),
      .hold_o    (hold[k]),
      .ovf_o     (ovf_o[k])
    );
  end

  assign dat_o      = dat_q;
  assign update_o   = update_q;
  assign gate_cnt_o = gate_cnt_q;

endmodule

// File: tb/tb_trigger_scaler_bank.sv
// Randomised and directed bench for trigger_scaler_bank against a count-level reference model.
module tb_trigger_scaler_bank;

  localparam int NCH  = 8;
  localparam int W    = 4;
  localparam int P    = 10;
  localparam int MAXC = (1 << W) - 1;

  logic           mclk  = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] flag  = '0;
  logic [NCH-1:0] mask  = '0;
  logic           mode  = 1'b0;
  logic           pps   = 1'b0;
  logic [2:0]     sel   = '0;
  logic [W-1:0]   dat;
  logic [NCH-1:0] ovf;
  logic           upd;
  logic [15:0]    gc;

  always #5 mclk = ~mclk;

  trigger_scaler_bank #(
    .NCHAN(NCH),
    .WIDTH(W),
    .PERIOD_CYCLES(P)
  ) dut (
    .mclk_i    (mclk),
    .rst_n_i   (rst_n),
    .flag_i    (flag),
    .mask_i    (mask),
    .pps_mode_i(mode),
    .pps_i     (pps),
    .sel_i     (sel),
    .dat_o     (dat),
    .ovf_o     (ovf),
    .update_o  (upd),
    .gate_cnt_o(gc)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: true per-gate pulse totals, clipped only when snapshotted.
  int m_cnt [NCH];
  int m_hold[NCH];
  bit m_ovf [NCH];
  int e_dat, e_gc, age;
  bit e_upd, m_pps_q;

  always @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        m_cnt[k] = 0; m_hold[k] = 0; m_ovf[k] = 0;
      end
      e_dat = 0; e_gc = 0; age = 0; e_upd = 0; m_pps_q = 0;
    end else begin
      bit ge;
      int c;
      ge = mode ? (pps && !m_pps_q) : (age == P - 1);
      e_dat = (int'(sel) < NCH) ? m_hold[sel] : 0;
      for (int k = 0; k < NCH; k++) begin
        c = m_cnt[k] + ((flag[k] && !mask[k]) ? 1 : 0);
        if (ge) begin
          m_hold[k] = (c > MAXC) ? MAXC : c;
          m_ovf[k]  = (c >= MAXC);
          m_cnt[k]  = 0;
        end else begin
          m_cnt[k] = c;
        end
      end
      if (ge) age = 0;
      else if (age < P - 1) age = age + 1;
      m_pps_q = pps;
      e_upd = ge;
      e_gc = (e_gc + (ge ? 1 : 0)) % 65536;
    end
  end

  always @(negedge mclk) begin
    if (rst_n) begin
      logic [NCH-1:0] eo;
      for (int k = 0; k < NCH; k++) eo[k] = m_ovf[k];
      check("dat", 32'(dat), 32'(e_dat));
      check("ovf", 32'(ovf), 32'(eo));
      check("update", 32'(upd), 32'(e_upd));
      check("gate_cnt", 32'(gc), 32'(e_gc));
    end
  end

  // Update interval monitor; runs on posedge so it sees last cycle's update.
  int since = 0, last_iv = 0, n_upd = 0;
  always @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      since = 0;
    end else begin
      since++;
      if (upd) begin
        last_iv = since; since = 0; n_upd++;
      end
    end
  end

  task automatic wait_upd(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge mclk);
      n++;
    end while (!upd && n < budget);
    if (!upd) check("update_timeout", 0, 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_dat"}, 32'(dat), 0);
    check({tag, "_ovf"}, 32'(ovf), 0);
    check({tag, "_update"}, 32'(upd), 0);
    check({tag, "_gate_cnt"}, 32'(gc), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, base;
    repeat (3) @(negedge mclk);
    #1 check_zero_outputs("reset");
    #1 rst_n = 1'b1;

    // Three pulses on channel 0 in the first gate.
    n = 0;
    do begin
      @(negedge mclk);
      n++;
      flag[0] = (n == 1 || n == 3 || n == 5);
    end while (!upd && n < 30);
    flag = '0;
    check("t1_first_update_cycle", n, P);
    check("t1_gate_cnt", 32'(gc), 1);
    @(negedge mclk);
    check("t1_dat", 32'(dat), 3);
    wait_upd(30);
    @(negedge mclk);
    check("t1_period", last_iv, P);

    // Pulse on the gate-end cycle lands in the closing snapshot.
    repeat (8) @(negedge mclk);
    flag[1] = 1'b1; sel = 3'd1;
    @(negedge mclk);
    flag = '0;
    check("t2_update_on_edge", 32'(upd), 1);
    @(negedge mclk);
    check("t2_hold_edge_pulse", 32'(dat), 1);
    wait_upd(30);
    @(negedge mclk);
    check("t2_next_gate_zero", 32'(dat), 0);

    // Masked channel 2 never counts, channel 3 does.
    mask = 8'b0000_0100;
    for (int i = 0; i < 4; i++) begin
      flag[3:2] = 2'b11;
      @(negedge mclk);
      flag = '0;
      @(negedge mclk);
    end
    wait_upd(30);
    sel = 3'd2;
    @(negedge mclk);
    check("t3_masked_ch2", 32'(dat), 0);
    sel = 3'd3;
    @(negedge mclk);
    check("t3_unmasked_ch3", 32'(dat), 4);
    mask = '0;

    // Reset mid-gate discards partial counts.
    wait_upd(30);
    for (int i = 0; i < 4; i++) begin
      flag[4] = 1'b1;
      @(negedge mclk);
      flag = '0;
      @(negedge mclk);
    end
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("t4_reset");
    repeat (2) @(negedge mclk);
    #2 rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge mclk);
      n++;
      flag[4] = (n == 2 || n == 4);
    end while (!upd && n < 30);
    flag = '0;
    sel = 3'd4;
    check("t4_first_update_cycle", n, P);
    @(negedge mclk);
    check("t4_post_reset_count", 32'(dat), 2);
    check("t4_gate_cnt", 32'(gc), 1);

    // PPS mode: edges 25 cycles apart, each held high 5 cycles.
    mode = 1'b1;
    repeat (3) @(negedge mclk);
    base = n_upd;
    for (int p = 0; p < 4; p++) begin
      pps = 1'b1;
      @(negedge mclk);
      check("t5_update_on_pps", 32'(upd), 1);
      @(negedge mclk);
      check("t5_update_one_cycle", 32'(upd), 0);
      repeat (3) @(negedge mclk);
      pps = 1'b0;
      repeat (20) @(negedge mclk);
    end
    check("t5_snapshots_per_pps", n_upd - base, 4);
    check("t5_pps_interval", last_iv, 25);

    // Saturation on channel 7 over a long PPS gate, then recovery.
    pps = 1'b1;
    @(negedge mclk);
    pps = 1'b0;
    for (int i = 0; i < 20; i++) begin
      flag[7] = 1'b1;
      @(negedge mclk);
    end
    flag = '0;
    sel = 3'd7;
    pps = 1'b1;
    @(negedge mclk);
    pps = 1'b0;
    check("t6_ovf7_set", 32'(ovf[7]), 1);
    @(negedge mclk);
    check("t6_hold7_sat", 32'(dat), 15);
    for (int i = 0; i < 2; i++) begin
      flag[7] = 1'b1;
      @(negedge mclk);
      flag = '0;
      @(negedge mclk);
    end
    pps = 1'b1;
    @(negedge mclk);
    pps = 1'b0;
    check("t6_ovf7_clear", 32'(ovf[7]), 0);
    @(negedge mclk);
    check("t6_hold7_two", 32'(dat), 2);

    // Randomised traffic; the model compare covers every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge mclk);
      flag = 8'($urandom & $urandom);
      sel  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) mask = 8'($urandom & $urandom);
      if ($urandom_range(0, 15) == 0) pps = ~pps;
      if ($urandom_range(0, 299) == 0) mode = ~mode;
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge mclk);
        #2 rst_n = 1'b1;
      end
    end
    repeat (2) @(negedge mclk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
